// File: rtl/session_pkg.sv
// Shared types and constants for the play-session controller.
// Holds the FSM state encoding, player-table geometry and default score width.
package session_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ARMED       = 3'd1,
    PLAYING     = 3'd2,
    LOGOUT      = 3'd3,
    LOGOUT_WAIT = 3'd4
  } sessState_t;

  localparam int PLAYER_W    = 3;
  localparam int PLAYER_N    = 8;
  localparam int SCORE_W_DEF = 8;
  localparam int SEC_W       = 7;

endpackage

// File: rtl/session_ctrl_if.sv
// Bundle of authentication, user-button and game-core signals around session_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface session_ctrl_if
  import session_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
);
  logic                LoggedIn;
  logic [PLAYER_W-1:0] PlayerID;
  logic                isGuest;
  logic                StartBtn;
  logic                LogoutBtn;
  logic                GameDone;
  logic [SCORE_W-1:0]  GameScore;
  logic                logout_to_auth;
  logic                GameStart;
  logic                SessionActive;
  logic [PLAYER_W-1:0] ActivePlayer;
  logic [SEC_W-1:0]    TimeLeft;
  logic [SCORE_W-1:0]  BestScore;
  logic                NewRecord;

  modport master (
    output LoggedIn, PlayerID, isGuest, StartBtn, LogoutBtn, GameDone, GameScore,
    input  logout_to_auth, GameStart, SessionActive, ActivePlayer, TimeLeft,
           BestScore, NewRecord
  );

  modport slave (
    input  LoggedIn, PlayerID, isGuest, StartBtn, LogoutBtn, GameDone, GameScore,
    output logout_to_auth, GameStart, SessionActive, ActivePlayer, TimeLeft,
           BestScore, NewRecord
  );
endinterface

// File: rtl/second_tick.sv
// Prescaler producing a one-cycle strobe every TICKS cycles while run is high.
// clear restarts the count so the first strobe lands TICKS cycles later.
module second_tick #(
  parameter int TICKS = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic tick
);
  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/session_ctrl.sv
// One play session per login: session/idle timers, game handshakes,
// per-player best-score table and the logout pulse back to authentication.
module session_ctrl
  import session_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int SESSION_SEC   = 60,
  parameter int GUEST_SEC     = 30,
  parameter int IDLE_SEC      = 15,
  parameter int SCORE_W       = SCORE_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  session_ctrl_if.slave bus
);
  localparam logic [SEC_W-1:0] SESSION_LD = SEC_W'(SESSION_SEC);
  localparam logic [SEC_W-1:0] GUEST_LD   = SEC_W'(GUEST_SEC);
  localparam logic [SEC_W-1:0] IDLE_LD    = SEC_W'(IDLE_SEC);

  sessState_t          state;
  logic [PLAYER_W-1:0] activePlayer;
  logic                guestReg;
  logic [SEC_W-1:0]    timeLeft;
  logic [SEC_W-1:0]    idleCnt;
  logic [SCORE_W-1:0]  bestScore;
  logic                gameStart;
  logic                logoutPulse;
  logic                sessionActive;
  logic                newRecord;

  logic [SCORE_W-1:0]  scoreRow [PLAYER_N];
  logic                tick;
  logic                inSession;
  logic                loadSession;
  logic                logoutCause;
  logic                scoreWrite;

  always_comb begin
    inSession   = (state == ARMED) || (state == PLAYING);
    loadSession = (state == IDLE) && bus.LoggedIn;
    logoutCause = bus.LogoutBtn
               || (tick && (timeLeft == SEC_W'(1)))
               || (tick && (state == ARMED) && (idleCnt == SEC_W'(1)));
    // A finishing round is still scored when a logout cause lands on the same edge.
    scoreWrite  = (state == PLAYING) && bus.LoggedIn && bus.GameDone && !guestReg
               && (bus.GameScore > scoreRow[activePlayer]);
  end

  second_tick #(
    .TICKS (TICKS_PER_SEC)
  ) u_second_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (loadSession),
    .run   (inSession),
    .tick  (tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < PLAYER_N; gi++) begin : g_entry
      logic [SCORE_W-1:0] entry;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          entry <= '0;
        end else if (scoreWrite && (activePlayer == PLAYER_W'(gi))) begin
          entry <= bus.GameScore;
        end
      end
      assign scoreRow[gi] = entry;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      activePlayer  <= '0;
      guestReg      <= 1'b0;
      timeLeft      <= '0;
      idleCnt       <= '0;
      bestScore     <= '0;
      gameStart     <= 1'b0;
      logoutPulse   <= 1'b0;
      sessionActive <= 1'b0;
      newRecord     <= 1'b0;
    end else begin
      gameStart   <= 1'b0;
      logoutPulse <= 1'b0;
      newRecord   <= scoreWrite;
      if (scoreWrite) bestScore <= bus.GameScore;

      case (state)
        IDLE: begin
          if (bus.LoggedIn) begin
            state         <= ARMED;
            activePlayer  <= bus.PlayerID;
            guestReg      <= bus.isGuest;
            timeLeft      <= bus.isGuest ? GUEST_LD : SESSION_LD;
            idleCnt       <= IDLE_LD;
            sessionActive <= 1'b1;
            bestScore     <= bus.isGuest ? '0 : scoreRow[bus.PlayerID];
          end
        end
        ARMED, PLAYING: begin
          if (!bus.LoggedIn) begin
            state         <= IDLE;
            sessionActive <= 1'b0;
          end else begin
            if (tick && (timeLeft != '0)) timeLeft <= timeLeft - SEC_W'(1);
            if ((state == ARMED) && tick && (idleCnt != '0)) idleCnt <= idleCnt - SEC_W'(1);
            if (logoutCause) begin
              state         <= LOGOUT;
              logoutPulse   <= 1'b1;
              sessionActive <= 1'b0;
            end else if ((state == ARMED) && bus.StartBtn) begin
              state     <= PLAYING;
              gameStart <= 1'b1;
            end else if ((state == PLAYING) && bus.GameDone) begin
              state   <= ARMED;
              idleCnt <= IDLE_LD;
            end
          end
        end
        LOGOUT: state <= LOGOUT_WAIT;
        LOGOUT_WAIT: begin
          if (!bus.LoggedIn) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.logout_to_auth = logoutPulse;
  assign bus.GameStart      = gameStart;
  assign bus.SessionActive  = sessionActive;
  assign bus.ActivePlayer   = activePlayer;
  assign bus.TimeLeft       = timeLeft;
  assign bus.BestScore      = bestScore;
  assign bus.NewRecord      = newRecord;

endmodule

// File: doc/session_ctrl.md
# session_ctrl

Downstream consumer of the authentication stage. It takes the logged-in status, player ID and guest flag, and runs one play session per login. Each session has a session timer and an idle timer, and game start/done handshakes with the game core. It keeps a per-player best-score table and produces the logout pulse that the authentication stage receives as `logout_from_gamectrl`.

## Interface
- `TICKS_PER_SEC`, default 50000000: clk cycles per one-second tick.
- `SESSION_SEC`, default 60: session length for registered players, range 1..127.
- `GUEST_SEC`, default 30: session length for guests, range 1..127.
- `IDLE_SEC`, default 15: maximum time in ARMED without a game start, range 1..127.
- `SCORE_W`, default 8: score width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `LoggedIn` in 1: level signal from authentication.
- `PlayerID` in 3: player ID from authentication; valid while `LoggedIn` is high.
- `isGuest` in 1: guest flag from authentication; valid while `LoggedIn` is high.
- `StartBtn` in 1: debounced single-cycle request to start a game.
- `LogoutBtn` in 1: debounced single-cycle user logout request.
- `GameDone` in 1: single-cycle pulse from the game core; the round has finished.
- `GameScore` in `SCORE_W`: score; valid with `GameDone`.
- `logout_to_auth` out 1: one-cycle logout pulse to authentication.
- `GameStart` out 1: one-cycle pulse to the game core.
- `SessionActive` out 1: high in ARMED and PLAYING.
- `ActivePlayer` out 3: player ID latched at session start.
- `TimeLeft` out 7: remaining session seconds.
- `BestScore` out `SCORE_W`: stored best score of `ActivePlayer`; 0 for guests.
- `NewRecord` out 1: one-cycle pulse when the stored best score is raised.

## Operation
- Reset values: state IDLE, all outputs 0, all 8 score-table entries 0, prescaler 0.
- IDLE → ARMED when `LoggedIn` is high.
  - Latch `PlayerID` and `isGuest`.
  - Load `TimeLeft` with `GUEST_SEC` for a guest, otherwise `SESSION_SEC`.
  - Load the idle counter with `IDLE_SEC` and clear the prescaler.
- ARMED → PLAYING on `StartBtn`; `GameStart` pulses on that same edge.
- PLAYING → ARMED on `GameDone`; the idle counter is reloaded to `IDLE_SEC`.
- Score update on `GameDone` in PLAYING for a non-guest:
  - If `GameScore` is strictly greater than the table entry, write the entry and pulse `NewRecord` for one cycle.
  - Guests never write the table.
- ARMED or PLAYING → LOGOUT on any of:
  - `LogoutBtn`;
  - a second tick while `TimeLeft` is 1 (`TimeLeft` becomes 0);
  - a second tick in ARMED while the idle counter is 1.
- LOGOUT: `logout_to_auth` is high for exactly one cycle, then the FSM moves to LOGOUT_WAIT.
- LOGOUT_WAIT → IDLE when `LoggedIn` is low.
- `LoggedIn` falling in ARMED or PLAYING → IDLE directly, with no logout pulse.
- Priority on a single edge: `LoggedIn` low, then logout causes, then `GameDone`/`StartBtn`.
  - A `GameDone` on the same edge as a logout cause still records its score.
  - It does not return the FSM to ARMED.
- `StartBtn` outside ARMED, `GameDone` outside PLAYING, and `LogoutBtn` outside ARMED/PLAYING are ignored.
- `TimeLeft` decrements once per second tick in ARMED and PLAYING and never wraps below 0. The idle counter decrements only in ARMED.
- `TimeLeft` holds its value in LOGOUT, LOGOUT_WAIT and IDLE until the next session load.

## Timing
- All outputs are registered.
- `GameStart` and the ARMED→PLAYING transition happen on the edge that samples `StartBtn`.
- The second tick is a one-cycle strobe issued when the prescaler reaches `TICKS_PER_SEC`-1. The prescaler then wraps to 0 and runs only in ARMED and PLAYING.
- The first tick comes `TICKS_PER_SEC` cycles after entry to ARMED from IDLE.
- A timeout logout means `logout_to_auth` is high on the cycle after the tick edge.
- `BestScore` reflects a table write one cycle after the `GameDone` edge.
- Asserting reset mid-operation returns everything to reset values immediately. No logout pulse is issued; authentication resets on the same `rst`.

## Structure
- Shared package `session_pkg` holds:
  - state encodings IDLE, ARMED, PLAYING, LOGOUT, LOGOUT_WAIT;
  - the player ID width constant (3) and player count (8);
  - the default `SCORE_W`.
- Sub-module `second_tick`: parameterised prescaler with a clear input and a one-cycle tick output.
- The FSM, counters and score table stay in `session_ctrl`.

## Test plan
All scenarios use `TICKS_PER_SEC`=4, `SESSION_SEC`=5, `GUEST_SEC`=2, `IDLE_SEC`=3.
- Login as ID 3, `StartBtn`, then `GameDone` with score 42 → `GameStart` pulses once; `NewRecord` pulses; `BestScore`=42. A second game with score 40 → no `NewRecord`, `BestScore` stays 42.
- Login as a guest with no activity → `TimeLeft` 2→1→0. `logout_to_auth` pulses once, 9 cycles after ARMED entry. The FSM then holds in LOGOUT_WAIT until `LoggedIn` drops.
- Registered login with no start → idle logout on the third tick (`TimeLeft`=2).
- `GameDone` with score 99 on the same edge as `LogoutBtn` → score recorded and `NewRecord` pulses, FSM goes to LOGOUT, and no `GameStart` follows.
- `LoggedIn` dropped in PLAYING → IDLE, `SessionActive`=0, no logout pulse.
- Reset asserted during PLAYING → all outputs and table entries 0 immediately. After release with `LoggedIn` high, a new session starts with `TimeLeft`=5.
